uart_tx_rr_arbiter: RTL and testbench
=====================================

Name: uart_tx_rr_arbiter

Overview:
- Shares the single UART transmit FIFO write port (w_data/wr_uart, tx_full) among N_REQ packet sources, e.g. the ALU result path, a status reporter and a debug dump.
- Uses round-robin arbitration with packet lock: a granted source keeps the port until it sends its last byte or its watchdog timeout expires.
- Sits between the per-source framing logic and the UART TX FIFO.

Parameters:
- DBIT, 8, data bits per UART byte (must be at least 8).
- N_REQ, 4, number of requesters (2 to 8).
- TIMEOUT_CYC, 1024, idle cycles in SEND before the grant is revoked.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high
- req  input  N_REQ  per-source packet request (level)
- valid  input  N_REQ  per-source byte valid
- last  input  N_REQ  per-source marks the final byte of the packet
- data  input  N_REQ*DBIT  per-source byte; source i occupies bits [i*DBIT +: DBIT]
- tx_full  input  1  UART TX FIFO full
- w_data  output  DBIT  byte to the TX FIFO
- wr_uart  output  1  TX FIFO write strobe
- grant  output  N_REQ  one-hot registered grant
- ready  output  N_REQ  per-source byte-accept
- busy  output  1  high whenever the state is not IDLE
- timeout_err  output  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Reset is asynchronous on reset, active-high, clock clk. Reset values:
  - state = IDLE, grant = 0, busy = 0, timeout_err = 0
  - rr_ptr = N_REQ-1, so source 0 has first priority
  - idle counter = 0
  - ready = 0, wr_uart = 0 and w_data = 0, because these are derived from grant
- Reset mid-packet drops the grant immediately. The partial packet is abandoned with no recovery byte.
- States are IDLE and SEND (plus HDR, see Optional Feature).
- IDLE:
  - If any req bit is set, pick the first set bit searching rr_ptr+1, rr_ptr+2, … modulo N_REQ.
  - The grant register is loaded on that edge and the state moves to SEND.
  - Latency: req sampled in cycle t gives grant in cycle t+1.
- SEND, with granted index g:
  - ready[g] = ~tx_full (combinational); all other ready bits are 0.
  - A transfer occurs when valid[g] && ready[g].
  - wr_uart = transfer and w_data = data[g] are combinational. A transfer in cycle t therefore writes the FIFO at the end of cycle t, and no over-write is possible when tx_full is accurate each cycle.
  - A transfer with last[g]: go to IDLE, grant cleared, rr_ptr = g. The next grant comes at the earliest two cycles later (one dead IDLE cycle).
  - req[g] deasserting mid-packet is ignored; the grant is held until last or timeout.
- Watchdog:
  - The idle counter clears on every transfer and on entry to SEND.
  - It increments in SEND only when valid[g]=0 and tx_full=0; FIFO back-pressure never counts.
  - When the counter reaches TIMEOUT_CYC-1 and would increment: timeout_err pulses for one cycle, the state goes to IDLE, grant is cleared and rr_ptr = g.
- last without valid has no effect. valid on a non-granted source is ignored (its ready is 0).
- Simultaneous requests are resolved only by the rr_ptr order; a single requester is re-granted back-to-back.

Optional Feature:
- Macro: UART_ARB_ID_HEADER_EN.
- With the macro defined:
  - The IDLE→SEND path passes through HDR for one or more cycles.
  - In HDR: w_data = 8'hA0 | g (zero-extended to DBIT), wr_uart = ~tx_full, all ready bits are 0.
  - HDR advances to SEND when the header write occurs. The watchdog is inactive in HDR.
- Without the macro: HDR does not exist and IDLE goes directly to SEND.

Decomposition:
- Package uart_arb_pkg holds:
  - the state encoding localparams (IDLE, SEND, HDR)
  - HDR_BASE = 8'hA0
  - a function clog2 for sizing rr_ptr and the counter
- One sub-module: rr_picker, a combinational round-robin priority search with inputs req and rr_ptr and outputs a one-hot pick and any_req.

Test Plan:
1. Single source: req[0]=1, bytes 8'h11 then 8'h22 (last), tx_full=0 → grant=4'b0001 one cycle after req; wr_uart high on 2 consecutive cycles with w_data 11, 22; grant=0 the cycle after 22.
2. Fairness: req=4'b1111 held, each source sends a 1-byte last packet → grant order 0,1,2,3,0 with one dead cycle between grants.
3. Back-pressure: tx_full=1 for 50 cycles mid-packet with valid=1 → ready[g]=0, wr_uart=0, no timeout_err; packet completes after tx_full drops.
4. Timeout: TIMEOUT_CYC=16, source 2 granted, valid=0 → timeout_err pulses exactly 16 cycles after the grant; grant=0; next grant goes to source 3 when req=4'b1100.
5. Async reset asserted mid-packet (source 1, 2 bytes sent) → grant=0 and wr_uart=0 immediately; after release with req=4'b0011, grant goes to source 0.
6. With UART_ARB_ID_HEADER_EN defined: source 3 sends 8'h5A (last) → w_data sequence A3, 5A.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX round-robin arbiter.
// HDR is only reachable when UART_ARB_ID_HEADER_EN is defined.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      HDR  = 2'd2
   } state_e;

   localparam logic [7:0] HDR_BASE = 8'hA0;

   // Ceiling log2, used to size the rotation pointer and watchdog counter
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((r < 32) && ((64'd1 << r) < 64'(n))) r++;
      return r;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set req bit after rr_ptr, modulo N_REQ.
module rr_picker #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] rr_ptr,
   output logic [N_REQ-1:0] pick,
   output logic             any_req
);

   logic             found;
   logic [PTR_W-1:0] idx;

   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         idx = PTR_W'((32'(rr_ptr) + k) % N_REQ);
         if (!found && req[idx]) begin
            pick[idx] = 1'b1;
            found     = 1'b1;
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/uart_tx_rr_arbiter.sv
// Round-robin arbiter with packet lock and idle watchdog in front of the UART TX FIFO.
// Define UART_ARB_ID_HEADER_EN to emit an 8'hA0|id header byte before each packet.
module uart_tx_rr_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned DBIT        = 8,
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_REQ-1:0]      req,
   input  logic [N_REQ-1:0]      valid,
   input  logic [N_REQ-1:0]      last,
   input  logic [N_REQ*DBIT-1:0] data,
   input  logic                  tx_full,
   output logic [DBIT-1:0]       w_data,
   output logic                  wr_uart,
   output logic [N_REQ-1:0]      grant,
   output logic [N_REQ-1:0]      ready,
   output logic                  busy,
   output logic                  timeout_err
);

   localparam int unsigned PTR_W = (clog2(N_REQ) < 1) ? 1 : clog2(N_REQ);
   localparam int unsigned CNT_W = (clog2(TIMEOUT_CYC) < 1) ? 1 : clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

   state_e             state_q, state_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
   logic               timeout_err_q, timeout_err_d;

   logic [N_REQ-1:0]   pick;
   logic               any_req;
   logic [PTR_W-1:0]   gidx;
   logic               xfer;
   logic [DBIT-1:0]    data_arr [N_REQ];

   for (genvar i = 0; i < N_REQ; i++) begin : g_slice
      assign data_arr[i] = data[i*DBIT +: DBIT];
   end

   rr_picker #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_picker (
      .req     (req),
      .rr_ptr  (rr_ptr_q),
      .pick    (pick),
      .any_req (any_req)
   );

   // Binary index of the one-hot grant
   always_comb begin
      gidx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_q[i]) gidx = PTR_W'(i);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         grant_q       <= '0;
         rr_ptr_q      <= PTR_W'(N_REQ - 1);
         idle_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         rr_ptr_q      <= rr_ptr_d;
         idle_cnt_q    <= idle_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      rr_ptr_d      = rr_ptr_q;
      idle_cnt_d    = idle_cnt_q;
      timeout_err_d = 1'b0;
      ready         = '0;
      wr_uart       = 1'b0;
      w_data        = '0;
      xfer          = 1'b0;

      case (state_q)
         IDLE: begin
            if (any_req) begin
               grant_d    = pick;
               idle_cnt_d = '0;
`ifdef UART_ARB_ID_HEADER_EN
               state_d    = HDR;
`else
               state_d    = SEND;
`endif
            end
         end

         SEND: begin
            ready   = grant_q & {N_REQ{~tx_full}};
            xfer    = valid[gidx] & ~tx_full;
            wr_uart = xfer;
            w_data  = data_arr[gidx];
            if (xfer) begin
               idle_cnt_d = '0;
               if (last[gidx]) begin
                  state_d  = IDLE;
                  grant_d  = '0;
                  rr_ptr_d = gidx;
               end
            end else if (!valid[gidx] && !tx_full) begin
               // Only a stalled source counts; FIFO back-pressure never does
               if (idle_cnt_q == CNT_MAX) begin
                  timeout_err_d = 1'b1;
                  state_d       = IDLE;
                  grant_d       = '0;
                  rr_ptr_d      = gidx;
                  idle_cnt_d    = '0;
               end else begin
                  idle_cnt_d = idle_cnt_q + CNT_W'(1);
               end
            end
         end

`ifdef UART_ARB_ID_HEADER_EN
         HDR: begin
            wr_uart = ~tx_full;
            w_data  = DBIT'(HDR_BASE | 8'(gidx));
            if (!tx_full) begin
               state_d    = SEND;
               idle_cnt_d = '0;
            end
         end
`endif

         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   assign grant       = grant_q;
   assign busy        = (state_q != IDLE);
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_rr_arbiter.sv
// Directed vector bench for uart_tx_rr_arbiter (N_REQ=4, DBIT=8, TIMEOUT_CYC=16).
module tb_uart_tx_rr_arbiter;

   localparam int unsigned DBIT        = 8;
   localparam int unsigned N_REQ       = 4;
   localparam int unsigned TIMEOUT_CYC = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req, valid, last;
   logic [31:0] data;
   logic        tx_full;
   logic [7:0]  w_data;
   logic        wr_uart;
   logic [3:0]  grant, ready;
   logic        busy, timeout_err;

   int n_tests = 0;
   int n_fail  = 0;

   uart_tx_rr_arbiter #(
      .DBIT        (DBIT),
      .N_REQ       (N_REQ),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .valid       (valid),
      .last        (last),
      .data        (data),
      .tx_full     (tx_full),
      .w_data      (w_data),
      .wr_uart     (wr_uart),
      .grant       (grant),
      .ready       (ready),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [3:0]  valid;
      logic [3:0]  last;
      logic [31:0] data;
      logic        tx_full;
      logic [3:0]  e_grant;
      logic [3:0]  e_ready;
      logic        e_wr;
      logic [7:0]  e_wdata;
      logic        e_busy;
      logic        e_terr;
   } vec_t;

   function automatic vec_t mk(input logic rst, input logic [3:0] rq, input logic [3:0] v,
                               input logic [3:0] l, input logic [31:0] d, input logic tf,
                               input logic [3:0] eg, input logic [3:0] er, input logic ew,
                               input logic [7:0] ewd, input logic eb, input logic et);
      vec_t x;
      x.rst = rst; x.req = rq; x.valid = v; x.last = l; x.data = d; x.tx_full = tf;
      x.e_grant = eg; x.e_ready = er; x.e_wr = ew; x.e_wdata = ewd; x.e_busy = eb; x.e_terr = et;
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [3:0] eg, input logic [3:0] er,
                            input logic ew, input logic [7:0] ewd, input logic eb, input logic et);
      chk({tag, " grant"},       32'(grant),       32'(eg));
      chk({tag, " ready"},       32'(ready),       32'(er));
      chk({tag, " wr_uart"},     32'(wr_uart),     32'(ew));
      chk({tag, " w_data"},      32'(w_data),      32'(ewd));
      chk({tag, " busy"},        32'(busy),        32'(eb));
      chk({tag, " timeout_err"}, 32'(timeout_err), 32'(et));
   endtask

   // Inputs change on the falling edge; outputs are sampled 1ns later
   task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] v,
                        input logic [3:0] l, input logic [31:0] d, input logic tf);
      @(negedge clk);
      reset = r; req = rq; valid = v; last = l; data = d; tx_full = tf;
      #1;
   endtask

   localparam logic [31:0] D4 = 32'h44332211;

   vec_t tbl[$];

   initial begin
      reset = 1'b1; req = 4'b0001; valid = '0; last = '0; data = '0; tx_full = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_all("reset", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0);

`ifdef UART_ARB_ID_HEADER_EN
      drive(1'b0, 4'b1000, 4'b0000, 4'b0000, 32'h0, 1'b0);
      check_all("hdr_req",   4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0);
      drive(1'b0, 4'b1000, 4'b0000, 4'b0000, 32'h0, 1'b1);
      check_all("hdr_full",  4'b1000, 4'b0000, 1'b0, 8'hA3, 1'b1, 1'b0);
      drive(1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b0);
      check_all("hdr_write", 4'b1000, 4'b0000, 1'b1, 8'hA3, 1'b1, 1'b0);
      drive(1'b0, 4'b0000, 4'b1000, 4'b1000, 32'h5A000000, 1'b0);
      check_all("hdr_data",  4'b1000, 4'b1000, 1'b1, 8'h5A, 1'b1, 1'b0);
      drive(1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b0);
      check_all("hdr_done",  4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0);
`else
      // Single source, two-byte packet
      tbl.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 32'h0,  0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
      tbl.push_back(mk(0, 4'b0001, 4'b0001, 4'b0000, 32'h11, 0, 4'b0001, 4'b0001, 1, 8'h11, 1, 0));
      tbl.push_back(mk(0, 4'b0001, 4'b0001, 4'b0001, 32'h22, 0, 4'b0001, 4'b0001, 1, 8'h22, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 32'h0,  0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
      // Fairness from a fresh reset: 0,1,2,3,0 with a dead cycle between grants
      tbl.push_back(mk(1, 4'b1111, 4'b0000, 4'b0000, 32'h0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, D4,    0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b1111, 4'b1111, D4,    0, 4'b0001, 4'b0001, 1, 8'h11, 1, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, D4,    0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b1111, 4'b1111, D4,    0, 4'b0010, 4'b0010, 1, 8'h22, 1, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, D4,    0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b1111, 4'b1111, D4,    0, 4'b0100, 4'b0100, 1, 8'h33, 1, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, D4,    0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b1111, 4'b1111, D4,    0, 4'b1000, 4'b1000, 1, 8'h44, 1, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, D4,    0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
      tbl.push_back(mk(0, 4'b1111, 4'b1111, 4'b1111, D4,    0, 4'b0001, 4'b0001, 1, 8'h11, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, D4,    0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
      // Source 1 mid-packet, req dropped, then async reset; source 0 wins afterwards
      tbl.push_back(mk(0, 4'b0010, 4'b0000, 4'b0000, 32'h0,    0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
      tbl.push_back(mk(0, 4'b0010, 4'b0010, 4'b0000, 32'hB100, 0, 4'b0010, 4'b0010, 1, 8'hB1, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 4'b0010, 4'b0000, 32'hB200, 0, 4'b0010, 4'b0010, 1, 8'hB2, 1, 0));
      tbl.push_back(mk(1, 4'b0011, 4'b0010, 4'b0000, 32'hB300, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
      tbl.push_back(mk(0, 4'b0011, 4'b0000, 4'b0000, 32'h0,    0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));
      // Foreign valid and last-without-valid leave the packet open
      tbl.push_back(mk(0, 4'b0011, 4'b0010, 4'b0001, 32'hC0,   0, 4'b0001, 4'b0001, 0, 8'hC0, 1, 0));
      tbl.push_back(mk(0, 4'b0011, 4'b0001, 4'b0001, 32'hC0,   0, 4'b0001, 4'b0001, 1, 8'hC0, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 32'h0,    0, 4'b0000, 4'b0000, 0, 8'h00, 0, 0));

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].req, tbl[i].valid, tbl[i].last, tbl[i].data, tbl[i].tx_full);
         check_all($sformatf("vec%0d", i), tbl[i].e_grant, tbl[i].e_ready, tbl[i].e_wr,
                   tbl[i].e_wdata, tbl[i].e_busy, tbl[i].e_terr);
      end

      // Back-pressure: 50 full cycles with valid held must not trip the watchdog
      drive(1'b0, 4'b0100, 4'b0000, 4'b0000, 32'h0, 1'b0);
      check_all("bp_req",   4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0);
      drive(1'b0, 4'b0000, 4'b0100, 4'b0000, 32'h00D10000, 1'b1);
      check_all("bp_grant", 4'b0100, 4'b0000, 1'b0, 8'hD1, 1'b1, 1'b0);
      for (int k = 0; k < 50; k++) begin
         drive(1'b0, 4'b0000, 4'b0100, 4'b0000, 32'h00D10000, 1'b1);
         check_all($sformatf("bp_hold%0d", k), 4'b0100, 4'b0000, 1'b0, 8'hD1, 1'b1, 1'b0);
      end
      drive(1'b0, 4'b0000, 4'b0100, 4'b0000, 32'h00D10000, 1'b0);
      check_all("bp_release", 4'b0100, 4'b0100, 1'b1, 8'hD1, 1'b1, 1'b0);
      drive(1'b0, 4'b0000, 4'b0100, 4'b0100, 32'h00D20000, 1'b0);
      check_all("bp_last",    4'b0100, 4'b0100, 1'b1, 8'hD2, 1'b1, 1'b0);
      drive(1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b0);
      check_all("bp_done",    4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0);

      // Watchdog: source 2 stalls, revoked 16 cycles after its grant, then source 3 wins
      drive(1'b0, 4'b0100, 4'b0000, 4'b0000, 32'h0, 1'b0);
      check_all("to_req",   4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0);
      drive(1'b0, 4'b1100, 4'b0000, 4'b0000, 32'h0, 1'b0);
      check_all("to_grant", 4'b0100, 4'b0100, 1'b0, 8'h00, 1'b1, 1'b0);
      for (int k = 2; k <= 16; k++) begin
         drive(1'b0, 4'b1100, 4'b0000, 4'b0000, 32'h0, 1'b0);
         check_all($sformatf("to_wait%0d", k), 4'b0100, 4'b0100, 1'b0, 8'h00, 1'b1, 1'b0);
      end
      drive(1'b0, 4'b1100, 4'b0000, 4'b0000, 32'h0, 1'b0);
      check_all("to_fire",    4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b1);
      drive(1'b0, 4'b1100, 4'b1000, 4'b1000, 32'hE3000000, 1'b0);
      check_all("to_regrant", 4'b1000, 4'b1000, 1'b1, 8'hE3, 1'b1, 1'b0);
      drive(1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b0);
      check_all("to_done",    4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
